program_loader: RTL and testbench

Boot-time program memory writer for the 8-bit pipelined core. It accepts a framed byte stream on a valid/ready interface, writes the payload into instruction memory from address 0, and checks an additive checksum. Only after a good frame does it release the core's reset. It also serves as the core's instruction memory: the core's fetch port reads it combinationally. It sits between the host link (UART receiver or test bench) and the core's ROM interface.

---
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time instruction memory writer for the 8-bit core.
// Parses SYNC / LEN / payload / checksum frames from a valid/ready byte
// stream, writes the payload into instruction memory from address 0 and
// releases the core's reset only after a frame whose checksum is good.
// The memory doubles as the core's instruction ROM (combinational fetch).
module program_loader #(
   parameter int         INST_ADDR_WIDTH = 8,
   parameter int         INST_DATA_WIDTH = 8,
   parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic [7:0]                 s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [INST_ADDR_WIDTH-1:0] inst_addr,
   output logic [INST_DATA_WIDTH-1:0] inst_data,
   output logic                       cpu_rst,
   output logic                       done,
   output logic                       error,
   output logic [8:0]                 byte_count
);

   localparam int DEPTH = 2 ** INST_ADDR_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CHK  = 3'd3,
      ST_RUN  = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   state_t                       state_r;
   logic [8:0]                   n_r;
   logic [INST_ADDR_WIDTH-1:0]   wr_ptr_r;
   logic [7:0]                   sum_r;
   logic [8:0]                   byte_count_r;
   logic                         s_ready_r;
   logic                         cpu_rst_r;
   logic                         done_r;
   logic                         error_r;
   logic                         accept_s;
   logic                         mem_we_s;
   logic [INST_DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];

   // Additive checksum step, modulo 256.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   // Payload length from the length byte: zero encodes a full 256-byte frame.
   function automatic logic [8:0] frame_len(input logic [7:0] l);
      if (l == 8'd0) begin
         return 9'd256;
      end else begin
         return {1'b0, l};
      end
   endfunction

   assign accept_s = s_valid && s_ready_r;

   // Memory write strobe: payload bytes accepted in DATA, suppressed during reset.
   always_comb begin
      mem_we_s = 1'b0;
      if (!arst && accept_s && (state_r == ST_DATA)) begin
         mem_we_s = 1'b1;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Frame parser FSM with registered handshake and core-control outputs.
   always_ff @(posedge clk) begin
      if (arst) begin
         state_r      <= ST_IDLE;
         n_r          <= 9'd0;
         wr_ptr_r     <= '0;
         sum_r        <= 8'd0;
         byte_count_r <= 9'd0;
         s_ready_r    <= 1'b0;
         cpu_rst_r    <= 1'b1;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         s_ready_r <= 1'b1;
         if (accept_s) begin
            case (state_r)
               ST_IDLE: begin
                  if (s_data == SYNC_BYTE) begin
                     state_r <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  n_r          <= frame_len(s_data);
                  wr_ptr_r     <= '0;
                  sum_r        <= 8'd0;
                  byte_count_r <= 9'd0;
                  state_r      <= ST_DATA;
               end
               ST_DATA: begin
                  wr_ptr_r     <= wr_ptr_r + 1'b1;
                  sum_r        <= csum_add(sum_r, s_data);
                  byte_count_r <= byte_count_r + 9'd1;
                  if ((byte_count_r + 9'd1) == n_r) begin
                     state_r <= ST_CHK;
                  end
               end
               ST_CHK: begin
                  if (csum_add(sum_r, s_data) == 8'd0) begin
                     state_r   <= ST_RUN;
                     cpu_rst_r <= 1'b0;
                     done_r    <= 1'b1;
                  end else begin
                     state_r <= ST_ERR;
                     error_r <= 1'b1;
                  end
               end
               ST_RUN: begin
                  // Reload: put the core back into reset for the whole new frame.
                  if (s_data == SYNC_BYTE) begin
                     state_r   <= ST_LEN;
                     cpu_rst_r <= 1'b1;
                     done_r    <= 1'b0;
                  end
               end
               ST_ERR: begin
                  if (s_data == SYNC_BYTE) begin
                     state_r <= ST_LEN;
                     error_r <= 1'b0;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  cpu_rst_r <= 1'b1;
                  done_r    <= 1'b0;
                  error_r   <= 1'b0;
               end
            endcase
         end
      end
   end

   // Instruction memory write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[wr_ptr_r] <= s_data;
      end
   end

   assign inst_data  = mem_r[inst_addr];
   assign s_ready    = s_ready_r;
   assign cpu_rst    = cpu_rst_r;
   assign done       = done_r;
   assign error      = error_r;
   assign byte_count = byte_count_r;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized frames checked every cycle
// against a frame-level behavioural model, plus literal expectations.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       arst;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] inst_addr;
   logic [7:0] inst_data;
   logic       cpu_rst;
   logic       done;
   logic       error;
   logic [8:0] byte_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   program_loader #(
      .INST_ADDR_WIDTH(8),
      .INST_DATA_WIDTH(8),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .arst(arst),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .inst_addr(inst_addr),
      .inst_data(inst_data),
      .cpu_rst(cpu_rst),
      .done(done),
      .error(error),
      .byte_count(byte_count)
   );

   // ---------------- behavioural model ----------------
   // status: 0 = nothing loaded, 1 = good program, 2 = bad checksum
   bit         m_started = 1'b0;
   bit         m_ready   = 1'b0;
   bit         m_in_frame = 1'b0;
   bit         m_have_len = 1'b0;
   int         m_len = 0;
   int         m_cnt = 0;
   int         m_sum = 0;
   int         m_status = 0;
   logic [7:0] m_mem [256];
   bit         m_vld [256];

   task automatic model_byte(input logic [7:0] b);
      if (!m_in_frame) begin
         if (b == 8'hA5) begin
            m_in_frame = 1'b1;
            m_have_len = 1'b0;
         end
      end else if (!m_have_len) begin
         m_len      = (b == 8'h00) ? 256 : int'(b);
         m_cnt      = 0;
         m_sum      = 0;
         m_have_len = 1'b1;
      end else if (m_cnt < m_len) begin
         m_mem[m_cnt % 256] = b;
         m_vld[m_cnt % 256] = 1'b1;
         m_cnt = m_cnt + 1;
         m_sum = m_sum + int'(b);
      end else begin
         m_in_frame = 1'b0;
         m_status   = (((m_sum + int'(b)) % 256) == 0) ? 1 : 2;
      end
   endtask

   always @(posedge clk) begin
      if (arst) begin
         m_ready    = 1'b0;
         m_in_frame = 1'b0;
         m_have_len = 1'b0;
         m_cnt      = 0;
         m_sum      = 0;
         m_status   = 0;
         m_started  = 1'b1;
      end else begin
         if (s_valid && m_ready) model_byte(s_data);
         m_ready = 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT outputs with the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_started) begin
         check("s_ready", s_ready, m_ready);
         check("cpu_rst", cpu_rst, !((m_status == 1) && !m_in_frame));
         check("done", done, (m_status == 1) && !m_in_frame);
         check("error", error, (m_status == 2) && !m_in_frame);
         check("byte_count", byte_count, m_cnt);
         if (m_vld[inst_addr]) check("inst_data", inst_data, m_mem[inst_addr]);
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] fq[$];

   task automatic tick();
      @(posedge clk);
      #1;
      inst_addr = 8'($urandom_range(0, 255));
   endtask

   task automatic send(input logic [7:0] b, input int gap_max);
      int gap;
      int g;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         tick();
      end
      g = 0;
      while (s_ready !== 1'b1 && g < 8) begin
         tick();
         g++;
      end
      if (g >= 8) check("ready_timeout", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = b;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic send_queue(input int gap_max);
      foreach (fq[i]) send(fq[i], gap_max);
   endtask

   task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string name);
      inst_addr = a;
      #1;
      check(name, inst_data, exp);
   endtask

   task automatic good_frame(input int gap_max);
      fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      send_queue(gap_max);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int sum;
      logic [7:0] b;
      logic [7:0] c;
      arst      = 1'b1;
      s_valid   = 1'b0;
      s_data    = 8'h00;
      inst_addr = 8'h00;
      foreach (m_vld[i]) m_vld[i] = 1'b0;
      repeat (3) tick();
      check("rst_s_ready", s_ready, 1'b0);
      check("rst_cpu_rst", cpu_rst, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_byte_count", byte_count, 9'd0);
      arst = 1'b0;
      tick();

      // Good load
      fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
      send_queue(0);
      check("good_pre_cpu_rst", cpu_rst, 1'b1);
      send(8'h9A, 0);
      check("good_cpu_rst", cpu_rst, 1'b0);
      check("good_done", done, 1'b1);
      check("good_error", error, 1'b0);
      check("good_byte_count", byte_count, 9'd3);
      peek(8'd1, 8'h22, "good_mem1");
      peek(8'd0, 8'h11, "good_mem0");
      peek(8'd2, 8'h33, "good_mem2");

      // Bad checksum
      fq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
      send_queue(0);
      check("bad_error", error, 1'b1);
      check("bad_cpu_rst", cpu_rst, 1'b1);
      check("bad_done", done, 1'b0);
      peek(8'd0, 8'h10, "bad_mem0");
      peek(8'd1, 8'h20, "bad_mem1");
      peek(8'd2, 8'h33, "bad_mem2_kept");

      // Garbage before sync, then a good frame
      fq = '{8'h00, 8'hFF, 8'h5A};
      send_queue(0);
      check("garbage_error_held", error, 1'b1);
      good_frame(0);
      check("garbage_done", done, 1'b1);
      peek(8'd1, 8'h22, "garbage_mem1");

      // SYNC byte as payload data
      fq = '{8'hA5, 8'h03, 8'h11, 8'hA5, 8'h33, 8'h17};
      send_queue(0);
      check("syncdata_done", done, 1'b1);
      peek(8'd1, 8'hA5, "syncdata_mem1");

      // Full depth
      send(8'hA5, 0);
      send(8'h00, 0);
      for (int i = 0; i < 256; i++) send(8'(i), 0);
      send(8'h80, 0);
      check("full_done", done, 1'b1);
      check("full_byte_count", byte_count, 9'd256);
      peek(8'd255, 8'hFF, "full_mem255");
      peek(8'd0, 8'h00, "full_mem0");

      // Reload then reset mid-payload
      send(8'hA5, 0);
      check("reload_cpu_rst", cpu_rst, 1'b1);
      check("reload_done", done, 1'b0);
      send(8'h05, 0);
      send(8'h44, 0);
      send(8'h55, 0);
      arst = 1'b1;
      tick();
      check("midrst_s_ready", s_ready, 1'b0);
      check("midrst_cpu_rst", cpu_rst, 1'b1);
      tick();
      arst = 1'b0;
      tick();
      good_frame(0);
      check("afterrst_done", done, 1'b1);
      peek(8'd2, 8'h33, "afterrst_mem2");

      // Gapped valid
      good_frame(3);
      check("gapped_done", done, 1'b1);
      check("gapped_byte_count", byte_count, 9'd3);

      // Randomized frames
      for (int f = 0; f < 30; f++) begin
         repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b, 2);
         end
         len = (f == 17) ? 256 : int'($urandom_range(1, 24));
         send(8'hA5, 2);
         send(8'(len), 2);
         sum = 0;
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            sum = sum + int'(b);
            send(b, 2);
            if ($urandom_range(0, 199) == 0) begin
               arst = 1'b1;
               tick();
               tick();
               arst = 1'b0;
               tick();
               break;
            end
         end
         c = 8'(256 - (sum % 256));
         if ($urandom_range(0, 2) == 0) c = c + 8'd1;
         send(c, 2);
      end
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
